// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the two-port memory bus arbiter.
//             - arb_state_t : arbiter FSM state, 2-bit encoding
//             - PORT_CPU / PORT_AUX : port index constants
//             - HOLD_MAX_DEFAULT : default watchdog hold limit
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int HOLD_MAX_DEFAULT = 16;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module   : arb_hold_timer
//  Purpose  : 8-bit saturating count of consecutive granted cycles.
//  Ports    : CLK       in  clock
//             RST       in  asynchronous active-high reset
//             i_clear   in  restart the count (asserted on grant entry)
//             i_enable  in  count this cycle (asserted while a grant is held)
//             o_reached out this granted cycle is the HOLD_MAX-th or later
//  Revision : 1.0  initial release
// ============================================================================
module arb_hold_timer
    import mem_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_reached
);

    localparam logic [8:0] c_HOLD_MAX = 9'(HOLD_MAX);

    logic [7:0] r_count;
    logic [8:0] w_count_incl;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    // r_count holds the granted cycles already completed, so adding one
    // gives the count including the cycle currently in progress.
    assign w_count_incl = {1'b0, r_count} + 9'd1;
    assign o_reached    = i_enable && (w_count_incl >= c_HOLD_MAX);

endmodule : arb_hold_timer
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares one single-ported memory bus between the CPU (port 0)
//             and an auxiliary master (port 1) with a registered
//             request/grant handshake, a dead TURN cycle between owners and
//             a sticky hold watchdog.
//  Ports    : CLK, RST                clock, asynchronous active-high reset
//             REQ0/1 -> GNT0/1        request in, registered grant out
//             CS0/1, WE0/1, ADDR0/1,
//             WDATA0/1                master-side bus signals
//             CS, WE, ADDR, Mem_Bus   memory-side bus (Mem_Bus tristate)
//             RDATA                   Mem_Bus broadcast to both masters
//             TIMEOUT                 sticky watchdog flag
//             OWNER                   index of last granted port
//  Config   : ARB_ROUND_ROBIN_EN - when defined, ties go to the port that
//             was not the last owner; otherwise the CPU wins ties.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    output logic          GNT0,
    output logic          GNT1,
    input  logic          CS0,
    input  logic          CS1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic [DW-1:0] RDATA,
    output logic          CS,
    output logic          WE,
    output logic [AW-1:0] ADDR,
    inout  wire  [DW-1:0] Mem_Bus,
    output logic          TIMEOUT,
    output logic          OWNER
);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_owner;
    logic          r_timeout;
    logic          w_tie_winner;
    logic          w_enter;
    logic          w_in_own;
    logic          w_other_req;
    logic          w_reached;
    logic          w_cs;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // The last-owner register doubles as the round-robin pointer: both
    // reset to 0 and both update on every grant entry.
`ifdef ARB_ROUND_ROBIN_EN
    assign w_tie_winner = ~r_owner;
`else
    assign w_tie_winner = PORT_CPU;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (REQ0 && REQ1) begin
                    w_next = (w_tie_winner == PORT_AUX) ? OWN1 : OWN0;
                end else if (REQ0) begin
                    w_next = OWN0;
                end else if (REQ1) begin
                    w_next = OWN1;
                end
            end
            OWN0:    if (!REQ0) w_next = TURN;
            OWN1:    if (!REQ1) w_next = TURN;
            TURN:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_in_own    = (r_state == OWN0) || (r_state == OWN1);
    assign w_enter     = (r_state == IDLE) && ((w_next == OWN0) || (w_next == OWN1));
    assign w_other_req = (r_state == OWN1) ? REQ0 : REQ1;

    // Grants are decoded from the next state so they are true flops that
    // track the state register exactly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_owner   <= PORT_CPU;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt0  <= (w_next == OWN0);
            r_gnt1  <= (w_next == OWN1);
            if (w_enter) begin
                r_owner <= (w_next == OWN1);
            end
            // Flag only; the owner keeps the bus.
            if (w_reached && w_other_req) begin
                r_timeout <= 1'b1;
            end
        end
    end

    arb_hold_timer #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_timer (
        .CLK       (CLK),
        .RST       (RST),
        .i_clear   (w_enter),
        .i_enable  (w_in_own),
        .o_reached (w_reached)
    );

    // Only the current owner's controls reach memory; IDLE and TURN park
    // the bus with everything deasserted.
    always_comb begin
        w_cs    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            OWN0: begin
                w_cs    = CS0;
                w_we    = WE0;
                w_addr  = ADDR0;
                w_wdata = WDATA0;
            end
            OWN1: begin
                w_cs    = CS1;
                w_we    = WE1;
                w_addr  = ADDR1;
                w_wdata = WDATA1;
            end
            default: begin
                w_cs    = 1'b0;
                w_we    = 1'b0;
                w_addr  = '0;
                w_wdata = '0;
            end
        endcase
    end

    assign CS      = w_cs;
    assign WE      = w_we;
    assign ADDR    = w_addr;
    assign Mem_Bus = w_we ? w_wdata : {DW{1'bz}};
    assign RDATA   = Mem_Bus;
    assign GNT0    = r_gnt0;
    assign GNT1    = r_gnt1;
    assign OWNER   = r_owner;
    assign TIMEOUT = r_timeout;

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Self-checking bench for mem_bus_arbiter: directed steps for
//             reset, read, write, isolation, ties, watchdog and async reset,
//             then randomized two-master traffic against a transaction-level
//             reference model and a 256-word memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int HOLD     = 4;
    localparam int N_RANDOM = 400;

    logic          CLK = 1'b0;
    logic          RST;
    logic          req   [2];
    logic          cs    [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    logic          GNT0, GNT1, CS, WE, TIMEOUT, OWNER;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] RDATA;
    wire  [DW-1:0] mem_bus;

    int n_checks;
    int n_errors;

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .HOLD_MAX (HOLD)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ0    (req[0]),
        .REQ1    (req[1]),
        .GNT0    (GNT0),
        .GNT1    (GNT1),
        .CS0     (cs[0]),
        .CS1     (cs[1]),
        .WE0     (we[0]),
        .WE1     (we[1]),
        .ADDR0   (addr[0]),
        .ADDR1   (addr[1]),
        .WDATA0  (wdata[0]),
        .WDATA1  (wdata[1]),
        .RDATA   (RDATA),
        .CS      (CS),
        .WE      (WE),
        .ADDR    (ADDR),
        .Mem_Bus (mem_bus),
        .TIMEOUT (TIMEOUT),
        .OWNER   (OWNER)
    );

    // Memory attached to the arbiter's memory side.
    logic [DW-1:0] tb_mem [256];

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
            tb_mem[16] <= 32'hDEAD_BEEF;
        end else if (CS && WE) begin
            tb_mem[ADDR[7:0]] <= mem_bus;
        end
    end

    assign mem_bus = (CS && !WE) ? tb_mem[ADDR[7:0]] : {DW{1'bz}};

    // ------------------------------------------------------------------
    // Reference model: who holds the bus, the first edge at which a new
    // grant may be made, last owner, sticky watchdog and memory contents.
    // ------------------------------------------------------------------
    int            m_gnt;
    int            m_free;
    int            m_owner;
    int            m_hold;
    logic          m_timeout;
    logic [DW-1:0] m_mem [256];
    int            n_edge;

    function automatic void model_reset();
        m_gnt     = -1;
        m_free    = 0;
        m_owner   = 0;
        m_hold    = 0;
        m_timeout = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_mem[16] = 32'hDEAD_BEEF;
    endfunction

    function automatic void model_edge();
        n_edge++;
        if (RST) begin
            model_reset();
        end else if (m_gnt >= 0) begin
            if (cs[m_gnt] && we[m_gnt]) m_mem[addr[m_gnt][7:0]] = wdata[m_gnt];
            if (m_hold < 255) m_hold++;
            if (m_hold >= HOLD && req[1-m_gnt]) m_timeout = 1'b1;
            if (!req[m_gnt]) begin
                // dead cycle, then an idle cycle; new grant two edges later
                m_gnt  = -1;
                m_free = n_edge + 2;
            end
        end else if (n_edge >= m_free && (req[0] || req[1])) begin
            if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                m_gnt = 1 - m_owner;
`else
                m_gnt = 0;
`endif
            end else begin
                m_gnt = req[0] ? 0 : 1;
            end
            m_owner = m_gnt;
            m_hold  = 0;
        end
    endfunction

    // An undriven bus reads as Z in four-state simulators and as 0 in
    // two-state ones; both map to 0. Driven write data is never 0.
    function automatic logic [DW-1:0] norm(input logic [DW-1:0] v);
        return (v === {DW{1'bz}}) ? '0 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic          ecs, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ebus;
        ecs   = 1'b0;
        ewe   = 1'b0;
        eaddr = '0;
        ebus  = '0;
        if (m_gnt >= 0) begin
            ecs   = cs[m_gnt];
            ewe   = we[m_gnt];
            eaddr = addr[m_gnt];
            if (ewe) ebus = wdata[m_gnt];
            else if (ecs) ebus = m_mem[eaddr[7:0]];
        end
        chk("gnt0", GNT0, m_gnt == 0);
        chk("gnt1", GNT1, m_gnt == 1);
        chk("cs", CS, ecs);
        chk("we", WE, ewe);
        chk("addr", ADDR, eaddr);
        chk("rdata", norm(RDATA), ebus);
        chk("mem_bus", norm(mem_bus), ebus);
        chk("timeout", TIMEOUT, m_timeout);
        chk("owner", OWNER, m_owner[0]);
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are
    // checked one unit later, then the model advances on the next edge.
    task automatic cycle();
        #1;
        check_all();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic wait_grant();
        int b;
        b = 0;
        while (m_gnt < 0 && b < 10) begin
            cycle();
            b++;
        end
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            req[p]   = 1'b0;
            cs[p]    = 1'b0;
            we[p]    = 1'b0;
            addr[p]  = '0;
            wdata[p] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int exp_seq [6];
        int cnt     [2];
        int len     [2];
        int w;

        n_checks = 0;
        n_errors = 0;
        n_edge   = 0;
        RST      = 1'b1;
        idle_inputs();
        model_reset();
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{1, 0, 1, 0, 1, 0};
`else
        exp_seq = '{0, 0, 0, 1, 1, 1};
`endif

        // ---- reset state ----
        @(posedge CLK);
        #1;
        cycle();
        cycle();
        chk("rst_gnt0", GNT0, 0);
        chk("rst_gnt1", GNT1, 0);
        chk("rst_timeout", TIMEOUT, 0);
        RST = 1'b0;

        // ---- single CPU read ----
        req[0] = 1'b1;
        cycle();
        chk("cpu_gnt_latency", GNT0, 1);
        cs[0]   = 1'b1;
        addr[0] = 32'h10;
        #1;
        chk("cpu_cs", CS, 1);
        chk("cpu_addr", ADDR, 32'h10);
        chk("cpu_rdata", norm(RDATA), 32'hDEAD_BEEF);
        cycle();
        cs[0]  = 1'b0;
        req[0] = 1'b0;
        cycle();
        chk("turn_gnt0", GNT0, 0);
        chk("turn_gnt1", GNT1, 0);

        // ---- AUX write, requested during TURN ----
        req[1] = 1'b1;
        cycle();
        chk("turn_wait_gnt1", GNT1, 0);
        cycle();
        chk("aux_gnt", GNT1, 1);
        cs[1]    = 1'b1;
        we[1]    = 1'b1;
        addr[1]  = 32'h20;
        wdata[1] = 32'h1234_5678;
        #1;
        chk("aux_bus_drive", norm(mem_bus), 32'h1234_5678);
        cycle();
        cs[1] = 1'b0;
        we[1] = 1'b0;
        #1;
        chk("aux_bus_release", norm(mem_bus), 0);
        req[1] = 1'b0;
        cycle();
        cycle();

        // ---- readback by CPU, then port 1 noise while CPU owns ----
        req[0] = 1'b1;
        cycle();
        cs[0]   = 1'b1;
        addr[0] = 32'h20;
        #1;
        chk("readback", norm(RDATA), 32'h1234_5678);
        cs[1]    = 1'b1;
        we[1]    = 1'b1;
        addr[1]  = 32'h30;
        wdata[1] = 32'hBADB_AD01;
        addr[0]  = 32'h30;
        #1;
        chk("iso_cs", CS, 1);
        chk("iso_we", WE, 0);
        chk("iso_addr", ADDR, 32'h30);
        chk("iso_rdata", norm(RDATA), 0);
        cycle();
        cycle();
        cs[1] = 1'b0;
        we[1] = 1'b0;
        cycle();
        #1;
        chk("iso_mem_unchanged", norm(RDATA), 0);
        idle_inputs();
        cycle();
        cycle();

        // ---- simultaneous requests, three transactions per port ----
        cnt[0] = 0;
        cnt[1] = 0;
        req[0] = 1'b1;
        req[1] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            wait_grant();
            w = GNT1 ? 1 : (GNT0 ? 0 : 2);
            chk("tie_winner", w, exp_seq[t]);
            if (m_gnt < 0) break;
            w = m_gnt;
            cnt[w]++;
            cycle();
            req[w] = 1'b0;
            cycle();
            if (cnt[w] < 3) req[w] = 1'b1;
        end
        idle_inputs();
        cycle();
        cycle();

        // ---- watchdog: CPU holds 10 cycles while AUX waits ----
        req[0] = 1'b1;
        wait_grant();
        req[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) req[0] = 1'b0;
            cycle();
            chk("wd_timeout", TIMEOUT, 32'(k >= HOLD));
            if (k < 10) chk("wd_gnt0_held", GNT0, 1);
        end
        wait_grant();
        req[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("wd_sticky", TIMEOUT, 1);
        end

        // ---- asynchronous reset in the middle of a write ----
        req[0] = 1'b1;
        wait_grant();
        cs[0]    = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 32'h40;
        wdata[0] = 32'hCAFE_F00D;
        #1;
        chk("prereset_bus", norm(mem_bus), 32'hCAFE_F00D);
        #1;
        RST = 1'b1;
        model_reset();
        #1;
        chk("arst_gnt0", GNT0, 0);
        chk("arst_cs", CS, 0);
        chk("arst_we", WE, 0);
        chk("arst_bus", norm(mem_bus), 0);
        chk("arst_timeout", TIMEOUT, 0);
        chk("arst_owner", OWNER, 0);
        cycle();
        idle_inputs();
        cycle();
        RST = 1'b0;

        // ---- randomized two-master traffic ----
        len[0] = 0;
        len[1] = 0;
        for (int c = 0; c < N_RANDOM; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && m_gnt == p) begin
                    if (len[p] == 0) begin
                        req[p] = 1'b0;
                        cs[p]  = 1'b0;
                        we[p]  = 1'b0;
                    end else begin
                        len[p]--;
                        cs[p]    = ($urandom_range(0, 3) != 0);
                        we[p]    = 1'($urandom_range(0, 1));
                        addr[p]  = 32'($urandom_range(0, 15));
                        wdata[p] = $urandom | 32'h1;
                    end
                end else begin
                    if (!req[p] && $urandom_range(0, 3) == 0) begin
                        req[p] = 1'b1;
                        len[p] = $urandom_range(1, 8);
                    end
                    cs[p]    = 1'($urandom_range(0, 1));
                    we[p]    = 1'($urandom_range(0, 1));
                    addr[p]  = $urandom;
                    wdata[p] = $urandom | 32'h1;
                end
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_bus_arbiter
`default_nettype wire
